// File: rtl/branch_predictor_btb.sv
// Dynamic branch predictor with a direct-mapped branch target buffer.
// Fetch looks up PCF combinationally. Each prediction rides the D and E pipeline
// registers. It is checked against the resolved branch in Execute, and the
// resolved branch trains the table.
module branch_predictor_btb #(
  parameter int unsigned INDEX_BITS = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          PCF,
  output logic                 PredTakenF,
  output logic [31:0]          PredTargetF,
  input  logic                 StallD,
  input  logic                 FlushD,
  input  logic                 FlushE,
  input  logic                 BranchE,
  input  logic                 BranchTakenE,
  input  logic [31:0]          BranchTargetE,
  output logic                 MispredictE,
  output logic [31:0]          RecoverPCE,
  output logic [CNT_WIDTH-1:0] BranchCount,
  output logic [CNT_WIDTH-1:0] MispredCount
);

  localparam int unsigned Entries = 2 ** INDEX_BITS;
  localparam int unsigned TagW    = 32 - INDEX_BITS - 2;

  // Table storage
  logic             valid_q  [Entries];
  logic [TagW-1:0]  tag_q    [Entries];
  logic [31:0]      target_q [Entries];
  logic [1:0]       ctr_q    [Entries];

  // Pipeline copies of the prediction
  logic        dec_valid_q, dec_pred_taken_q;
  logic [31:0] dec_pred_target_q, dec_pc_q;
  logic        ex_valid_q, ex_pred_taken_q;
  logic [31:0] ex_pred_target_q, ex_pc_q;

  logic [INDEX_BITS-1:0] idx_f, idx_e;
  logic [TagW-1:0]       tag_f, tag_e;
  logic                  hit_f, hit_e;

  assign idx_f = PCF[INDEX_BITS+1:2];
  assign tag_f = PCF[31:INDEX_BITS+2];
  assign idx_e = ex_pc_q[INDEX_BITS+1:2];
  assign tag_e = ex_pc_q[31:INDEX_BITS+2];

  // Fetch lookup and Execute check, both purely combinational
  always_comb begin
    hit_f       = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    hit_e       = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
    PredTakenF  = hit_f && ctr_q[idx_f][1];
    PredTargetF = PredTakenF ? target_q[idx_f] : PCF + 32'd4;
    MispredictE = 1'b0;
    if (ex_valid_q) begin
      if (BranchE) begin
        MispredictE = (ex_pred_taken_q != BranchTakenE) ||
                      (ex_pred_taken_q && BranchTakenE && (ex_pred_target_q != BranchTargetE));
      end else begin
        // A non-branch that hit a taken entry is an alias and must be undone
        MispredictE = ex_pred_taken_q;
      end
    end
    // Reset forces zero; otherwise the formula applies even when not mispredicting
    if (reset) begin
      RecoverPCE = '0;
    end else if (BranchE && BranchTakenE) begin
      RecoverPCE = BranchTargetE;
    end else begin
      RecoverPCE = ex_pc_q + 32'd4;
    end
  end

  // F->D prediction register: flush beats stall
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dec_valid_q       <= 1'b0;
      dec_pred_taken_q  <= 1'b0;
      dec_pred_target_q <= '0;
      dec_pc_q          <= '0;
    end else if (FlushD) begin
      dec_valid_q       <= 1'b0;
      dec_pred_taken_q  <= 1'b0;
      dec_pred_target_q <= '0;
      dec_pc_q          <= '0;
    end else if (!StallD) begin
      dec_valid_q       <= 1'b1;
      dec_pred_taken_q  <= PredTakenF;
      dec_pred_target_q <= PredTargetF;
      dec_pc_q          <= PCF;
    end
  end

  // D->E prediction register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_q       <= 1'b0;
      ex_pred_taken_q  <= 1'b0;
      ex_pred_target_q <= '0;
      ex_pc_q          <= '0;
    end else if (FlushE) begin
      ex_valid_q       <= 1'b0;
      ex_pred_taken_q  <= 1'b0;
      ex_pred_target_q <= '0;
      ex_pc_q          <= '0;
    end else begin
      ex_valid_q       <= dec_valid_q;
      ex_pred_taken_q  <= dec_pred_taken_q;
      ex_pred_target_q <= dec_pred_target_q;
      ex_pc_q          <= dec_pc_q;
    end
  end

  // Table training from the instruction resolving in Execute
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(Entries); i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (ex_valid_q) begin
      if (BranchE) begin
        if (hit_e) begin
          if (BranchTakenE) begin
            if (ctr_q[idx_e] != 2'b11) ctr_q[idx_e] <= ctr_q[idx_e] + 2'd1;
            target_q[idx_e] <= BranchTargetE;
          end else if (ctr_q[idx_e] != 2'b00) begin
            ctr_q[idx_e] <= ctr_q[idx_e] - 2'd1;
          end
        end else if (BranchTakenE) begin
          valid_q[idx_e]  <= 1'b1;
          tag_q[idx_e]    <= tag_e;
          target_q[idx_e] <= BranchTargetE;
          ctr_q[idx_e]    <= 2'b10;
        end
      end else if (ex_pred_taken_q && hit_e) begin
        valid_q[idx_e] <= 1'b0;
      end
    end
  end

  // Saturating statistics counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      BranchCount  <= '0;
      MispredCount <= '0;
    end else begin
      if (ex_valid_q && BranchE && (BranchCount != '1)) BranchCount <= BranchCount + 1'b1;
      if (MispredictE && (MispredCount != '1)) MispredCount <= MispredCount + 1'b1;
    end
  end

endmodule
